// File: rtl/intersection_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tl_pkg
// Description : Shared definitions for the intersection scheduler. Holds the
//               phase codes, the lamp encodings, the last-served type, the
//               default phase timings and the phase-to-lamp decode.
// Revision    : 1.0 - initial release
// ============================================================================
package tl_pkg;

    // Phase codes; these values appear directly on the phase output
    localparam logic [2:0] c_ST_MAIN_G   = 3'd0;
    localparam logic [2:0] c_ST_MAIN_Y   = 3'd1;
    localparam logic [2:0] c_ST_ALL_RED  = 3'd2;
    localparam logic [2:0] c_ST_SIDE_G   = 3'd3;
    localparam logic [2:0] c_ST_SIDE_Y   = 3'd4;
    localparam logic [2:0] c_ST_PED_WALK = 3'd5;

    // Lamp encodings {red,yellow,green}
    localparam logic [2:0] c_RED    = 3'b100;
    localparam logic [2:0] c_YELLOW = 3'b010;
    localparam logic [2:0] c_GREEN  = 3'b001;

    typedef enum logic {
        SERVED_SIDE = 1'b0,
        SERVED_PED  = 1'b1
    } served_t;

    // Default phase durations in clock cycles
    localparam int c_MAIN_MIN_G = 20;
    localparam int c_SIDE_MIN_G = 5;
    localparam int c_SIDE_MAX_G = 15;
    localparam int c_YELLOW_T   = 3;
    localparam int c_ALLRED_T   = 2;
    localparam int c_WALK_T     = 10;

    // Phase to {main_road, side_road, walk}; unknown codes show the
    // MAIN_G pattern because those codes recover to MAIN_G.
    function automatic logic [6:0] lamps(input logic [2:0] st);
        logic [6:0] l;
        case (st)
            c_ST_MAIN_Y:   l = {c_YELLOW, c_RED,    1'b0};
            c_ST_ALL_RED:  l = {c_RED,    c_RED,    1'b0};
            c_ST_SIDE_G:   l = {c_RED,    c_GREEN,  1'b0};
            c_ST_SIDE_Y:   l = {c_RED,    c_YELLOW, 1'b0};
            c_ST_PED_WALK: l = {c_RED,    c_RED,    1'b1};
            default:       l = {c_GREEN,  c_RED,    1'b0};
        endcase
        return l;
    endfunction

endpackage
`default_nettype wire

// File: rtl/intersection_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : intersection_scheduler_if
// Description : Request and lamp bundle of the intersection scheduler.
//               master : request source / lamp observer (environment)
//               slave  : the scheduler (reads requests, drives lamps)
//               SENSOR    - side-road vehicle present (level)
//               PED_REQ   - pedestrian button (any-length pulse)
//               main_road - main lamp {red,yellow,green}
//               side_road - side lamp {red,yellow,green}
//               walk      - pedestrian walk lamp
//               count     - cycles elapsed in current phase (saturating)
//               phase     - current phase code
// Revision    : 1.0 - initial release
// ============================================================================
interface intersection_scheduler_if;
    logic       SENSOR;
    logic       PED_REQ;
    logic [2:0] main_road;
    logic [2:0] side_road;
    logic       walk;
    logic [7:0] count;
    logic [2:0] phase;

    modport master (
        output SENSOR, PED_REQ,
        input  main_road, side_road, walk, count, phase
    );

    modport slave (
        input  SENSOR, PED_REQ,
        output main_road, side_road, walk, count, phase
    );
endinterface
`default_nettype wire

// File: rtl/intersection_scheduler_phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : phase_timer
// Description : 8-bit saturating cycle counter with synchronous clear.
//               clk     - clock
//               rst     - synchronous active-high reset (clears)
//               i_clr   - clear on next edge (first cycle of a new phase)
//               o_count - current count, holds at 255
// Revision    : 1.0 - initial release
// ============================================================================
module phase_timer (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       i_clr,
    output logic [7:0]      o_count
);
    logic [7:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= 8'd0;
        end else if (r_count != 8'hFF) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign o_count = r_count;
endmodule
`default_nettype wire

// File: rtl/intersection_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : intersection_scheduler
// Description : Main/side road traffic light controller with a pedestrian
//               walk phase. Main road rests green; side (SENSOR level) and
//               pedestrian (latched PED_REQ) requests are served alternately
//               with a return to main green between any two services.
//               clk - clock, rst - synchronous active-high reset,
//               bus - intersection_scheduler_if.slave (requests, lamps,
//                     phase count, phase code)
// Revision    : 1.0 - initial release
// ============================================================================
module intersection_scheduler
    import tl_pkg::*;
#(
    parameter int MAIN_MIN_G = c_MAIN_MIN_G,
    parameter int SIDE_MIN_G = c_SIDE_MIN_G,
    parameter int SIDE_MAX_G = c_SIDE_MAX_G,
    parameter int YELLOW_T   = c_YELLOW_T,
    parameter int ALLRED_T   = c_ALLRED_T,
    parameter int WALK_T     = c_WALK_T
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    intersection_scheduler_if.slave    bus
);
    // Count values on the last cycle of each timed phase
    localparam logic [7:0] c_MAIN_LAST = 8'(MAIN_MIN_G - 1);
    localparam logic [7:0] c_SMIN_LAST = 8'(SIDE_MIN_G - 1);
    localparam logic [7:0] c_SMAX_LAST = 8'(SIDE_MAX_G - 1);
    localparam logic [7:0] c_YEL_LAST  = 8'(YELLOW_T - 1);
    localparam logic [7:0] c_AR_LAST   = 8'(ALLRED_T - 1);
    localparam logic [7:0] c_WALK_LAST = 8'(WALK_T - 1);

    logic [2:0] r_state;
    logic [2:0] r_target;
    served_t    r_last;
    logic       r_ped_pending;
    logic [2:0] r_main_road;
    logic [2:0] r_side_road;
    logic       r_walk;

    logic [2:0] w_next;
    logic [2:0] w_target;
    logic [7:0] w_count;
    logic       w_clr;
    logic       w_enter_side;
    logic       w_enter_ped;

    always_comb begin
        w_next   = r_state;
        w_target = r_target;
        case (r_state)
            c_ST_MAIN_G: begin
                if (w_count >= c_MAIN_LAST && (bus.SENSOR || r_ped_pending))
                    w_next = c_ST_MAIN_Y;
            end
            c_ST_MAIN_Y: begin
                if (w_count == c_YEL_LAST) begin
                    w_next = c_ST_ALL_RED;
                    // On a tie, serve whoever did not go last
                    if (bus.SENSOR && r_ped_pending)
                        w_target = (r_last == SERVED_PED) ? c_ST_SIDE_G : c_ST_PED_WALK;
                    else if (bus.SENSOR)
                        w_target = c_ST_SIDE_G;
                    else if (r_ped_pending)
                        w_target = c_ST_PED_WALK;
                    else
                        w_target = c_ST_MAIN_G;
                end
            end
            c_ST_ALL_RED: begin
                if (w_count == c_AR_LAST) begin
                    // Fall back to the other requester if the chosen one left
                    case (r_target)
                        c_ST_SIDE_G:
                            w_next = bus.SENSOR ? c_ST_SIDE_G :
                                     (r_ped_pending ? c_ST_PED_WALK : c_ST_MAIN_G);
                        c_ST_PED_WALK:
                            w_next = r_ped_pending ? c_ST_PED_WALK :
                                     (bus.SENSOR ? c_ST_SIDE_G : c_ST_MAIN_G);
                        default:
                            w_next = c_ST_MAIN_G;
                    endcase
                end
            end
            c_ST_SIDE_G: begin
                if (w_count == c_SMAX_LAST || (!bus.SENSOR && w_count >= c_SMIN_LAST))
                    w_next = c_ST_SIDE_Y;
            end
            c_ST_SIDE_Y: begin
                if (w_count == c_YEL_LAST) begin
                    w_next   = c_ST_ALL_RED;
                    w_target = c_ST_MAIN_G;
                end
            end
            c_ST_PED_WALK: begin
                if (w_count == c_WALK_LAST) begin
                    w_next   = c_ST_ALL_RED;
                    w_target = c_ST_MAIN_G;
                end
            end
            default: begin
                w_next   = c_ST_MAIN_G;
                w_target = c_ST_MAIN_G;
            end
        endcase
    end

    assign w_clr        = (w_next != r_state);
    assign w_enter_side = (w_next == c_ST_SIDE_G)   && (r_state != c_ST_SIDE_G);
    assign w_enter_ped  = (w_next == c_ST_PED_WALK) && (r_state != c_ST_PED_WALK);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_ST_MAIN_G;
            r_target      <= c_ST_MAIN_G;
            r_last        <= SERVED_PED;
            r_ped_pending <= 1'b0;
            r_main_road   <= c_GREEN;
            r_side_road   <= c_RED;
            r_walk        <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_target <= w_target;
            if (w_enter_side)
                r_last <= SERVED_SIDE;
            else if (w_enter_ped)
                r_last <= SERVED_PED;
            // Entry clears pending; button presses during the walk are dropped
            if (w_enter_ped)
                r_ped_pending <= 1'b0;
            else if (bus.PED_REQ && r_state != c_ST_PED_WALK)
                r_ped_pending <= 1'b1;
            {r_main_road, r_side_road, r_walk} <= lamps(w_next);
        end
    end

    phase_timer u_phase_timer (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_clr),
        .o_count (w_count)
    );

    assign bus.main_road = r_main_road;
    assign bus.side_road = r_side_road;
    assign bus.walk      = r_walk;
    assign bus.count     = w_count;
    assign bus.phase     = r_state;
endmodule
`default_nettype wire

// File: tb/tb_intersection_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_intersection_scheduler
// Description : Directed self-checking bench for intersection_scheduler.
//               Cycle 0 is the first cycle after the reset edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_intersection_scheduler;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   cyc;
    int   bad;

    intersection_scheduler_if bus ();

    intersection_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic do_reset(input logic sensor);
        rst = 1'b1;
        bus.SENSOR  = sensor;
        bus.PED_REQ = 1'b1;      // must be ignored while in reset
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.PED_REQ = 1'b0;
        cyc = 0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        cyc = 0;
        rst = 1'b1;
        bus.SENSOR = 1'b0;
        bus.PED_REQ = 1'b0;
        step();

        // Idle: main green forever, count saturates
        do_reset(1'b0);
        check("rst_phase", int'(bus.phase), 0);
        check("rst_main", int'(bus.main_road), 1);
        check("rst_side", int'(bus.side_road), 4);
        check("rst_walk", int'(bus.walk), 0);
        check("rst_count", int'(bus.count), 0);
        bad = 0;
        while (cyc < 300) begin
            if (bus.main_road != 3'b001 || bus.phase != 3'd0) bad++;
            if (cyc == 254) check("count_254", int'(bus.count), 254);
            if (cyc == 255) check("count_255", int'(bus.count), 255);
            step();
        end
        check("idle_main_green_cycles_bad", bad, 0);
        check("count_sat", int'(bus.count), 255);

        // Side request held: full cycle timeline
        do_reset(1'b1);
        run_to(19); check("s_mg19", int'(bus.phase), 0);
        check("s_cnt19", int'(bus.count), 19);
        run_to(20); check("s_my20", int'(bus.phase), 1);
        check("s_main_y", int'(bus.main_road), 2);
        run_to(22); check("s_my22", int'(bus.phase), 1);
        run_to(23); check("s_ar23", int'(bus.phase), 2);
        check("s_ar_main", int'(bus.main_road), 4);
        run_to(25); check("s_sg25", int'(bus.phase), 3);
        check("s_side_g", int'(bus.side_road), 1);
        run_to(39); check("s_sg39", int'(bus.phase), 3);
        check("s_cnt39", int'(bus.count), 14);
        run_to(40); check("s_sy40", int'(bus.phase), 4);
        check("s_side_y", int'(bus.side_road), 2);
        run_to(41);
        // Reset in SIDE_Y count 1
        check("r_sy_cnt1", int'(bus.count), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("r_phase", int'(bus.phase), 0);
        check("r_main", int'(bus.main_road), 1);
        check("r_side", int'(bus.side_road), 4);
        check("r_count", int'(bus.count), 0);

        // Full side sequence to return
        do_reset(1'b1);
        run_to(43); check("s_ar43", int'(bus.phase), 2);
        run_to(44); check("s_ar44", int'(bus.phase), 2);
        run_to(45); check("s_mg45", int'(bus.phase), 0);
        check("s_mg45_main", int'(bus.main_road), 1);
        check("s_mg45_cnt", int'(bus.count), 0);

        // Side leaves early: SENSOR low from SIDE_G count 2
        do_reset(1'b1);
        run_to(27);
        bus.SENSOR = 1'b0;
        run_to(29); check("e_sg29", int'(bus.phase), 3);
        check("e_side29", int'(bus.side_road), 1);
        run_to(30); check("e_sy30", int'(bus.phase), 4);
        run_to(35); check("e_mg35", int'(bus.phase), 0);

        // Tie: side first (last_served=PED), then pedestrian
        do_reset(1'b1);
        run_to(3);
        bus.PED_REQ = 1'b1;
        step();
        bus.PED_REQ = 1'b0;
        run_to(25); check("t_sg25", int'(bus.phase), 3);
        run_to(45); check("t_mg45", int'(bus.phase), 0);
        run_to(64); check("t_mg64", int'(bus.phase), 0);
        run_to(65); check("t_my65", int'(bus.phase), 1);
        run_to(70); check("t_pw70", int'(bus.phase), 5);
        check("t_walk70", int'(bus.walk), 1);
        check("t_main70", int'(bus.main_road), 4);
        run_to(79); check("t_walk79", int'(bus.walk), 1);
        run_to(80); check("t_ar80", int'(bus.phase), 2);
        check("t_walk80", int'(bus.walk), 0);
        run_to(82); check("t_mg82", int'(bus.phase), 0);

        // Pedestrian only; press during walk is ignored
        do_reset(1'b0);
        bus.PED_REQ = 1'b1;
        step();
        bus.PED_REQ = 1'b0;
        run_to(20); check("p_my20", int'(bus.phase), 1);
        run_to(25); check("p_pw25", int'(bus.phase), 5);
        check("p_walk25", int'(bus.walk), 1);
        run_to(28);
        bus.PED_REQ = 1'b1;
        step();
        bus.PED_REQ = 1'b0;
        run_to(35); check("p_ar35", int'(bus.phase), 2);
        run_to(37); check("p_mg37", int'(bus.phase), 0);
        bad = 0;
        while (cyc < 137) begin
            if (bus.phase != 3'd0) bad++;
            step();
        end
        check("p_hold_bad", bad, 0);
        check("p_cnt137", int'(bus.count), 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/intersection_scheduler.md
INTERSECTION_SCHEDULER -- requirements
Module: intersection_scheduler

Interface
REQ-001 SHALL have one clock, clk; reset is rst, synchronous and active-high.
REQ-002 Parameter MAIN_MIN_G, 20, minimum main-road green in clk cycles (1 cycle = 1 s).
REQ-003 Parameter SIDE_MIN_G, 5, minimum side-road green in cycles.
REQ-004 Parameter SIDE_MAX_G, 15, maximum side-road green in cycles.
REQ-005 Parameter YELLOW_T, 3, yellow duration for either road in cycles.
REQ-006 Parameter ALLRED_T, 2, all-red clearance duration in cycles.
REQ-007 Parameter WALK_T, 10, pedestrian walk duration in cycles.
REQ-008 Port: clk  in  1  system clock.
REQ-009 Port: rst  in  1  synchronous active-high reset.
REQ-010 Port: SENSOR  in  1  side-road vehicle present (level).
REQ-011 Port: PED_REQ  in  1  pedestrian button (any-length pulse).
REQ-012 Port: main_road  out  3  main light {red,yellow,green}: 100 red, 010 yellow, 001 green.
REQ-013 Port: side_road  out  3  side light, same encoding.
REQ-014 Port: walk  out  1  pedestrian walk lamp.
REQ-015 Port: count  out  8  cycles elapsed in current phase.
REQ-016 Port: phase  out  3  current state code.

Function
REQ-017 States: MAIN_G=0, MAIN_Y=1, ALL_RED=2, SIDE_G=3, SIDE_Y=4, PED_WALK=5; codes 6-7 unreachable and SHALL recover to MAIN_G.
REQ-018 Outputs registered: MAIN_G 001/100/0; MAIN_Y 010/100/0; ALL_RED 100/100/0; SIDE_G 100/001/0; SIDE_Y 100/010/0; PED_WALK 100/100/1 (main/side/walk).
REQ-019 count clears to 0 on the first cycle of every state, increments by 1 each cycle, saturates at 255.
REQ-020 A state of duration N occupies exactly N cycles (count 0..N-1); transition fires at count==N-1.
REQ-021 ped_pending sets on any cycle PED_REQ=1, except in PED_WALK (ignored); clears on PED_WALK entry.
REQ-022 side request = SENSOR level, sampled each cycle; not latched.
REQ-023 MAIN_G -> MAIN_Y when count>=MAIN_MIN_G-1 and (SENSOR or ped_pending); otherwise hold.
REQ-024 MAIN_Y -> ALL_RED after YELLOW_T; on that transition target is latched: if only one request pending, that one; if both, the one not equal to last_served.
REQ-025 ALL_RED after ALLRED_T -> latched target (SIDE_G, PED_WALK, or MAIN_G).
REQ-026 If the latched request vanished (SENSOR dropped) by ALL_RED exit, go to the other pending requester, else MAIN_G.
REQ-027 SIDE_G -> SIDE_Y at count==SIDE_MAX_G-1, or earlier when SENSOR=0 and count>=SIDE_MIN_G-1.
REQ-028 SIDE_Y -> ALL_RED (target MAIN_G) after YELLOW_T; PED_WALK -> ALL_RED (target MAIN_G) after WALK_T.
REQ-029 last_served updates to SIDE/PED on entry to SIDE_G/PED_WALK.
REQ-030 Main road returns to MAIN_G between any two served requests; side and pedestrian never follow each other directly.

Reset
REQ-031 rst=1 at a clk edge SHALL, from that edge, force MAIN_G, count=0, main_road=001, side_road=100, walk=0, ped_pending=0, last_served=PED, target=MAIN_G, regardless of current state.
REQ-032 Requests during rst SHALL be ignored.

Structure
REQ-033 Package tl_pkg holds the state enum, light encodings (RED/YELLOW/GREEN) and default timing constants.
REQ-034 One sub-module, phase_timer: 8-bit saturating counter with synchronous clear, driving count.

Verification
REQ-035 Reset, SENSOR=0, PED_REQ=0 for 300 cycles -> main_road=001 throughout, count saturates at 255.
REQ-036 SENSOR=1 held from reset release (cycle 0) -> MAIN_G 0-19, MAIN_Y 20-22, ALL_RED 23-24, SIDE_G 25-39, SIDE_Y 40-42, ALL_RED 43-44, MAIN_G at 45.
REQ-037 SENSOR=1 then 0 at SIDE_G count 2 -> side green held to count 4, SIDE_Y at SIDE_G count 5.
REQ-038 PED_REQ one-cycle pulse at cycle 3 and SENSOR=1 -> SIDE_G first (tie, last_served=PED); after return to MAIN_G and 20 cycles, PED_WALK with walk=1 for 10 cycles.
REQ-039 PED_REQ pulsed during PED_WALK, SENSOR=0 -> after ALL_RED, MAIN_G held indefinitely (pulse ignored).
REQ-040 rst asserted at SIDE_Y count 1 -> next cycle main_road=001, side_road=100, count=0, phase=0.
